// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops plus iterative
// shift-add multiply and restoring divide behind a valid/ready handshake.
module alu_mc #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     Busy
);
    localparam int W       = DATA_WIDTH;
    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int CNT_W   = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND  = 4'b0000;
    localparam logic [OPCODE_LENGTH-1:0] OP_OR   = 4'b0001;
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = 4'b0010;
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = 4'b0011;
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = 4'b0100;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL  = 4'b0101;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT  = 4'b0110;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLTU = 4'b0111;
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ   = 4'b1000;
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL  = 4'b1001;
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA  = 4'b1010;
    localparam logic [OPCODE_LENGTH-1:0] OP_NE   = 4'b1011;

    logic [1:0]       state_q, state_d;
    logic [1:0]       iop_q, iop_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic [W-1:0]     b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     result_q, result_d;

    function automatic logic [W-1:0] alu_single(input logic [OPCODE_LENGTH-1:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [SHAMT_W-1:0] shamt;
        logic [W-1:0]       res;
        shamt = b[SHAMT_W-1:0];
        res   = '0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = $signed(a) >>> shamt;
            OP_SLT:  res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(W-1){1'b0}}, (a < b)};
            OP_EQ:   res = {{(W-1){1'b0}}, (a == b)};
            OP_NE:   res = {{(W-1){1'b0}}, (a != b)};
            default: res = '0;
        endcase
        return res;
    endfunction

    // One shift-add multiply step: {hi,lo} holds the partial product, lo shifts the multiplier out.
    logic [W:0]   mul_sum;
    logic [W-1:0] mul_hi, mul_lo;
    // One restoring divide step: hi is the partial remainder, lo shifts dividend out / quotient in.
    logic [W:0]   div_shift;
    logic         div_ge;
    logic [W-1:0] div_hi, div_lo;
    logic [W-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        mul_hi    = mul_sum[W:1];
        mul_lo    = {mul_sum[0], lo_q[W-1:1]};
        div_shift = {hi_q, lo_q[W-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_hi    = div_ge ? W'(div_shift - {1'b0, b_q}) : div_shift[W-1:0];
        div_lo    = {lo_q[W-2:0], div_ge};
        step_hi   = iop_q[1] ? div_hi : mul_hi;
        step_lo   = iop_q[1] ? div_lo : mul_lo;
    end

    always_comb begin
        state_d  = state_q;
        iop_d    = iop_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (Operation[3:2] != 2'b11) begin
                        result_d = alu_single(Operation, SrcA, SrcB);
                        state_d  = S_DONE;
                    end else if (Operation[1] && (SrcB == '0)) begin
                        result_d = Operation[0] ? SrcA : '1;
                        state_d  = S_DONE;
                    end else begin
                        iop_d   = Operation[1:0];
                        lo_d    = SrcA;
                        b_d     = SrcB;
                        hi_d    = '0;
                        cnt_d   = CNT_W'(W);
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    result_d = iop_q[0] ? step_hi : step_lo;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            iop_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            iop_q    <= iop_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Busy      = (state_q == S_BUSY);
    assign ALUResult = result_q;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a driver pushes expected results from an
// arithmetic reference model, a monitor pops and checks them as outputs appear.
module tb_alu_mc;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Busy;

    alu_mc #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
        .out_ready(out_ready), .ALUResult(ALUResult), .Busy(Busy)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          busy;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;
    int   cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", nm);
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned prod;
        int sh;
        sh   = int'(b % 32);
        prod = longint'(a) * longint'(b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a - b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return (a == b) ? 32'd1 : 32'd0;
            4'd9:  return a >> sh;
            4'd10: return $signed(a) >>> sh;
            4'd11: return (a != b) ? 32'd1 : 32'd0;
            4'd12: return prod[31:0];
            4'd13: return prod[63:32];
            4'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        exp_t e;
        int   n;
        bit   iter;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now({nm, "_accept"});
            in_valid = 1'b0;
            return;
        end
        iter   = (op >= 4'd12) && !((op >= 4'd14) && (b == 0));
        e.res  = model(op, a, b);
        e.lat  = iter ? 33 : 1;
        e.busy = iter ? 32 : 0;
        e.acc  = cyc + 1;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        SrcA      = $urandom;
        SrcB      = $urandom;
        Operation = 4'($urandom);
        @(negedge clk);
    endtask

    task automatic wait_done(input bit rand_ready);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            if (rand_ready) out_ready = 1'($urandom);
            n++;
        end while (!(sb.size() == 0 && !out_valid) && n < 300);
        out_ready = 1'b1;
        if (n >= 300) fail_now("wait_done");
    endtask

    // Monitor: checks result, latency and busy-cycle count when out_valid rises,
    // and result stability while out_valid is held.
    initial begin
        exp_t        e;
        logic        prev_ov;
        logic [31:0] held;
        int          busy_cnt;
        prev_ov  = 1'b0;
        held     = '0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                busy_cnt = 0;
                prev_ov  = 1'b0;
            end else begin
                if (Busy) busy_cnt++;
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_result"}, ALUResult, e.res);
                        check({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
                        check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.busy));
                    end
                    held     = ALUResult;
                    busy_cnt = 0;
                end else if (out_valid && prev_ov) begin
                    check("hold_result", ALUResult, held);
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        int n;
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        SrcA      = '0;
        SrcB      = '0;
        Operation = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", ALUResult, 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue("ADD", 4'd2, 32'h7FFF_FFFF, 32'd1);       wait_done(0);
        issue("SUB", 4'd3, 32'd0, 32'd1);               wait_done(0);
        issue("SRA", 4'd10, 32'h8000_0000, 32'h24);     wait_done(0);
        issue("SRL", 4'd9, 32'h8000_0000, 32'h24);      wait_done(0);
        issue("SLT", 4'd6, 32'hFFFF_FFFF, 32'd1);       wait_done(0);
        issue("SLTU", 4'd7, 32'hFFFF_FFFF, 32'd1);      wait_done(0);
        issue("NE", 4'd11, 32'd5, 32'd5);               wait_done(0);
        issue("MUL", 4'd12, 32'd7, 32'd6);              wait_done(0);
        issue("MULHU", 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(0);
        issue("DIVU", 4'd14, 32'd100, 32'd7);           wait_done(0);
        issue("REMU", 4'd15, 32'd100, 32'd7);           wait_done(0);
        issue("DIVU_by0", 4'd14, 32'h1234, 32'd0);      wait_done(0);
        issue("REMU_by0", 4'd15, 32'h1234, 32'd0);      wait_done(0);

        // Back-pressure: result held, a new request ignored until the result is taken.
        out_ready = 1'b0;
        issue("BP_ADD", 4'd2, 32'd3, 32'd4);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("bp_wait_valid");
        Operation = 4'd4;
        SrcA      = 32'hAAAA_5555;
        SrcB      = 32'h0F0F_0F0F;
        in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        issue("BP_XOR", 4'd4, 32'hAAAA_5555, 32'h0F0F_0F0F);
        wait_done(0);

        // Reset in the 10th busy cycle of a divide.
        issue("RST_DIVU", 4'd14, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("mid_busy", 32'(Busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_result", ALUResult, 32'd0);
        check("midrst_busy", 32'(Busy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        issue("AND", 4'd0, 32'hF0F0, 32'h0FF0);         wait_done(0);

        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 40));
                2:       b = a;
                default: b = $urandom;
            endcase
            issue("RAND", op, a, b);
            wait_done(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
